// File: rtl/cu_sequencer.sv
// Multi-cycle control-unit sequencer: START -> FETCH -> DECODE -> EXECUTE[xN]
// -> optional MEMORY -> optional EXCEPT -> START, with global stall and flush.
module cu_sequencer #(
    parameter int CNT_W    = 3,
    parameter int FETCH_HS = 1,
    parameter int IRQ_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             mem_ready,
    input  logic [CNT_W-1:0] exec_cycles,
    input  logic             write_rd,
    input  logic             update_flags,
    input  logic             mem_access,
    input  logic             mem_write,
    input  logic             branch_taken,
    input  logic             irq_pend,
    output logic             cu_fetch,
    output logic             cu_decode,
    output logic             cu_execute,
    output logic             cu_mem,
    output logic             mem_req,
    output logic             cu_wr_mem,
    output logic             new_pc_en,
    output logic             ld_pc,
    output logic             ld_rd,
    output logic             ld_apsr,
    output logic             ld_ipsr,
    output logic             ld_sp,
    output logic             ld_lr,
    output logic             ld_primask,
    output logic             flush,
    output logic             busy,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_START   = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_EXECUTE = 3'b011,
        S_MEMORY  = 3'b100,
        S_EXCEPT  = 3'b101
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             uf_q, uf_d;
    logic             ma_q, ma_d;
    logic             mw_q, mw_d;
    logic             flush_q, flush_d;

    logic             irq_take;
    logic             state_ok;

    assign irq_take = (IRQ_EN != 0) && irq_pend;
    assign state_ok = (state_q <= S_EXCEPT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        uf_d       = uf_q;
        ma_d       = ma_q;
        mw_d       = mw_q;
        flush_d    = 1'b0;
        cu_fetch   = 1'b0;
        cu_decode  = 1'b0;
        cu_execute = 1'b0;
        cu_mem     = 1'b0;
        mem_req    = 1'b0;
        cu_wr_mem  = 1'b0;
        new_pc_en  = 1'b0;
        ld_pc      = 1'b0;
        ld_rd      = 1'b0;
        ld_apsr    = 1'b0;
        ld_ipsr    = 1'b0;
        ld_sp      = 1'b0;
        ld_lr      = 1'b0;
        ld_primask = 1'b0;

        case (state_q)
            S_START: begin
                new_pc_en = 1'b1;
                ld_rd     = wr_q;
                ld_apsr   = uf_q;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                cu_fetch = 1'b1;
                mem_req  = 1'b1;
                if ((FETCH_HS == 0) || mem_ready) begin
                    ld_pc   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cu_decode = 1'b1;
                wr_d      = write_rd;
                uf_d      = update_flags;
                ma_d      = mem_access;
                mw_d      = mem_write;
                // A zero count still costs one EXECUTE cycle.
                cnt_d     = (exec_cycles == '0) ? '0 : exec_cycles - CNT_W'(1);
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                cu_execute = 1'b1;
                if (cnt_q == '0) begin
                    flush_d = branch_taken;
                    if (ma_q)          state_d = S_MEMORY;
                    else if (irq_take) state_d = S_EXCEPT;
                    else               state_d = S_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_MEMORY: begin
                cu_mem    = 1'b1;
                mem_req   = 1'b1;
                cu_wr_mem = mw_q;
                if (mem_ready) state_d = irq_take ? S_EXCEPT : S_START;
            end
            S_EXCEPT: begin
                ld_sp      = 1'b1;
                ld_lr      = 1'b1;
                ld_ipsr    = 1'b1;
                ld_primask = 1'b1;
                wr_d       = 1'b0;
                uf_d       = 1'b0;
                state_d    = S_START;
            end
            default: state_d = S_START;
        endcase

        // Stall freezes everything and kills strobes; mem_req/cu_wr_mem stay as decoded.
        if (stall && state_ok) begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            wr_d       = wr_q;
            uf_d       = uf_q;
            ma_d       = ma_q;
            mw_d       = mw_q;
            flush_d    = flush_q;
            new_pc_en  = 1'b0;
            ld_pc      = 1'b0;
            ld_rd      = 1'b0;
            ld_apsr    = 1'b0;
            ld_ipsr    = 1'b0;
            ld_sp      = 1'b0;
            ld_lr      = 1'b0;
            ld_primask = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_START;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            uf_q    <= 1'b0;
            ma_q    <= 1'b0;
            mw_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            uf_q    <= uf_d;
            ma_q    <= ma_d;
            mw_q    <= mw_d;
            flush_q <= flush_d;
        end
    end

    assign flush = flush_q && !stall;
    assign busy  = (state_q != S_START);
    assign state = state_q;

endmodule
